// File: rtl/tensor_dot_engine.sv
// Multi-lane signed dot-product engine: one shared activation per beat, LANES weight channels,
// results drained one lane per handshake. Optional build macro TDE_RELU_EN clamps negative outputs to 0.
module tensor_dot_engine #(
    parameter int DATA_W    = 8,
    parameter int LANES     = 2,
    parameter int VEC_LEN   = 4,
    parameter int ACC_W     = 18,
    parameter int OUT_SHIFT = 0,
    localparam int LANE_W   = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       a_in,
    input  logic [LANES*DATA_W-1:0] w_in,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_data,
    output logic [LANE_W-1:0]       out_lane,
    output logic                    busy
);

    localparam int IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(VEC_LEN - 1);
    localparam logic [LANE_W-1:0] PTR_LAST = LANE_W'(LANES - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [LANE_W-1:0]       ptr_q, ptr_d;
    logic signed [ACC_W-1:0] acc_q [LANES];
    logic signed [ACC_W-1:0] acc_d [LANES];

    logic accept;
    logic fire;

    // Product formed at full accumulator width so an undersized ACC_W simply wraps.
    function automatic logic signed [ACC_W-1:0] mac_term(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] w
    );
        logic signed [ACC_W-1:0] a_x;
        logic signed [ACC_W-1:0] w_x;
        a_x = ACC_W'(a);
        w_x = ACC_W'(w);
        return a_x * w_x;
    endfunction

    function automatic logic signed [ACC_W-1:0] shape_out(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] s;
        s = v >>> OUT_SHIFT;
`ifdef TDE_RELU_EN
        if (s < 0) begin
            s = '0;
        end
`endif
        return s;
    endfunction

    assign in_ready  = rst_n && ena && (state_q == ACCUM);
    assign out_valid = rst_n && ena && (state_q == DRAIN);
    assign accept    = in_valid && in_ready;
    assign fire      = out_valid && out_ready;

    assign out_lane  = ptr_q;
    assign out_data  = (state_q == DRAIN) ? shape_out(acc_q[ptr_q]) : '0;
    assign busy      = (idx_q != '0) || (state_q == DRAIN);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        for (int l = 0; l < LANES; l++) begin
            acc_d[l] = acc_q[l];
        end

        case (state_q)
            ACCUM: begin
                if (accept) begin
                    for (int l = 0; l < LANES; l++) begin
                        acc_d[l] = acc_q[l] + mac_term(a_in, w_in[l*DATA_W +: DATA_W]);
                    end
                    idx_d = idx_q + 1'b1;
                    if ((idx_q == IDX_LAST) || in_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (fire) begin
                    if (ptr_q == PTR_LAST) begin
                        // Last lane delivered: clear everything so the next beat starts fresh.
                        state_d = ACCUM;
                        ptr_d   = '0;
                        idx_d   = '0;
                        for (int l = 0; l < LANES; l++) begin
                            acc_d[l] = '0;
                        end
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            idx_q   <= '0;
            ptr_q   <= '0;
            for (int l = 0; l < LANES; l++) begin
                acc_q[l] <= '0;
            end
        end else if (ena) begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            for (int l = 0; l < LANES; l++) begin
                acc_q[l] <= acc_d[l];
            end
        end
    end

endmodule

// File: doc/tensor_dot_engine.md
Name: tensor_dot_engine

Overview:
- Parametrised multi-lane signed dot-product engine for the TensorFlowE tile.
- Streams one activation per beat, shared across LANES weight channels; each lane accumulates a*w[l] over a vector of up to VEC_LEN elements.
- After the vector ends, the lane results drain out one per handshake.
- Sits behind the tt_um top-level pin-muxing logic, which serialises pins into these handshakes.

Parameters:
- DATA_W, 8: signed operand width of activation and each weight.
- LANES, 2: parallel weight channels / results per vector (1..8).
- VEC_LEN, 4: maximum elements per dot product (>=1).
- ACC_W, 18: accumulator and result width. Must be >= 2*DATA_W + clog2(VEC_LEN).
- OUT_SHIFT, 0: arithmetic right shift applied to the result on output.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ena  in  1  global enable; low freezes all state.
- in_valid  in  1  input beat valid.
- in_ready  out  1  engine can accept a beat.
- a_in  in  DATA_W  signed activation.
- w_in  in  LANES*DATA_W  signed weights; lane l is bits [l*DATA_W +: DATA_W].
- in_last  in  1  beat is the final element of the vector (early end).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  ACC_W  signed result of lane out_lane.
- out_lane  out  clog2(LANES) (min 1)  lane index of out_data.
- busy  out  1  vector in progress or draining.

Behaviour:
- Reset (rst_n low at an edge):
  - state=ACCUM, idx=0, ptr=0, all accumulators 0.
  - out_valid=0, out_data=0, out_lane=0, busy=0.
  - in_ready=0 while rst_n is low.
  - Reset mid-vector or mid-drain discards all partial and undelivered results.
- ena low:
  - No register updates.
  - in_ready=0.
  - out_valid forced 0; a held result reappears unchanged when ena returns high.
- State ACCUM:
  - in_ready = ena.
  - Accept a beat when in_valid && in_ready.
  - For every lane l: acc[l] <= acc[l] + sext(a_in)*sext(w_l), signed, computed at ACC_W bits.
  - idx increments on each accepted beat.
  - If the accepted beat has idx==VEC_LEN-1 or in_last=1, the next state is DRAIN. The accumulators then include that beat's product.
  - in_last on the first beat gives a 1-element vector.
- State DRAIN:
  - in_ready=0; input is ignored.
  - out_valid=1 from the cycle after the final beat (latency 1 cycle).
  - out_lane=ptr; out_data = acc[ptr] >>> OUT_SHIFT (arithmetic shift).
  - On out_valid && out_ready: ptr increments and the next lane appears the following cycle.
  - Handshake on lane LANES-1: next state ACCUM, and ptr, idx and all accumulators clear in that same edge.
  - The next vector's first beat can be accepted the cycle after the last output handshake.
- out_ready low holds out_valid, out_data and out_lane stable indefinitely.
- busy=1 when idx!=0 or state==DRAIN.
- Overflow: cannot occur with legal ACC_W. If ACC_W is undersized, the result wraps modulo 2^ACC_W; there is no saturation.
- Simultaneous events: rst_n low overrides ena and all handshakes; ena low overrides handshakes.

Optional Feature:
- Macro TDE_RELU_EN.
- When defined: each result passes through ReLU after the shift. Negative values output as 0; non-negative values are unchanged. Accumulators are not clamped.
- When undefined: the raw shifted signed result is output.
- Handshake timing is identical either way.

Test Plan:
- Basic two-lane vector:
  - Setup: LANES=2, VEC_LEN=4, ACC_W=18.
  - Stimulus: a={1,2,3,4}, w0={5,6,7,8}, w1={-1,-1,-1,-1}, out_ready=1.
  - Expect: out_valid 1 cycle after the 4th beat; lane0=70 (0x00046), then lane1=-10 (0x3FFF6); in_ready=0 throughout the drain.
- Worst-case magnitude:
  - Stimulus: a=-128, w0=w1=-128 for 4 beats.
  - Expect: both lanes 65536 (0x10000), no wrap.
- Early end and clean restart:
  - Stimulus: in_last on the 2nd beat with a={2,3}, w0={4,5}.
  - Expect: lane0=23 after 2 beats. The next vector a={1}x4, w0={1}x4 gives 4, proving the accumulators cleared.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles during the drain, with in_valid=1 and varying a_in.
  - Expect: out_valid=1, and out_data/out_lane stay stable at lane0. Input beats are not accepted, and the results are unchanged after release.
- Reset and ena:
  - Stimulus: rst_n low for 1 cycle after 2 beats, then a full vector {1,1,1,1}·{1,1,1,1}.
  - Expect: lane0=4.
  - Stimulus: ena=0 for 3 cycles mid-vector.
  - Expect: in_ready=0, no state change, and the final result is identical to the run without the pause.
- Optional feature:
  - Stimulus: repeat the basic vector.
  - Expect with TDE_RELU_EN defined: lane1 out_data=0. Expect without it: 0x3FFF6. Lane0=70 in both builds.
